traffic_ctrl: RTL

Parametrised two-road intersection controller: the next generation of the team's fixed-delay main/side traffic FSM. It adds per-phase durations as parameters and a minimum main green. Side-road and pedestrian requests are latched. All-red clearance intervals and a night flashing mode are included. The block sits between the sensor/pushbutton conditioning logic and the lamp drivers; all outputs come from registers only.

---
 rtl/traffic_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/traffic_ctrl.sv
// ---------------------------------------------------------------------------
// traffic_ctrl
//
// Two-road (main/side) intersection controller with latched side-road and
// pedestrian requests, a guaranteed minimum main green, all-red clearance
// between the roads and a night flashing mode.
//
// Parameters:
//   CNT_W      phase timer width; every duration must be <= 2**CNT_W
//   MIN_GREEN  minimum main-green cycles
//   YEL_TIME   yellow cycles (both roads)
//   RED_CLR    all-red clearance cycles
//   SIDE_GREEN side-green cycles
//   FLASH_HALF half-period of the flash blink, in cycles
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   side_req   side-road vehicle sensor (level or pulse)
//   ped_req    pedestrian pushbutton (pulse); crossing runs with the side road
//   flash_en   night flashing mode request (level)
//   main_lt    main road lamps {R,Y,G}
//   side_lt    side road lamps {R,Y,G}
//   ped_walk   walk lamp
//   state      current state code (debug)
//
// Every output is a flop.  The lamp flops are loaded from the next-state
// decode, so the lamps always agree with the state register in the same
// cycle and no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module traffic_ctrl #(
    parameter int CNT_W      = 8,
    parameter int MIN_GREEN  = 20,
    parameter int YEL_TIME   = 4,
    parameter int RED_CLR    = 2,
    parameter int SIDE_GREEN = 10,
    parameter int FLASH_HALF = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_req,
    input  logic       ped_req,
    input  logic       flash_en,
    output logic [2:0] main_lt,
    output logic [2:0] side_lt,
    output logic       ped_walk,
    output logic [2:0] state
);

    localparam logic [2:0] S_MG    = 3'd0;
    localparam logic [2:0] S_MY    = 3'd1;
    localparam logic [2:0] S_AR1   = 3'd2;
    localparam logic [2:0] S_SG    = 3'd3;
    localparam logic [2:0] S_SY    = 3'd4;
    localparam logic [2:0] S_AR2   = 3'd5;
    localparam logic [2:0] S_FLASH = 3'd6;

    // Terminal timer values: a phase of N cycles exits when tmr == N-1.
    localparam logic [CNT_W-1:0] MG_LAST  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YEL_TIME - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(RED_CLR - 1);
    localparam logic [CNT_W-1:0] SG_LAST  = CNT_W'(SIDE_GREEN - 1);
    localparam logic [CNT_W-1:0] FH_LAST  = CNT_W'(FLASH_HALF - 1);

    logic [CNT_W-1:0] tmr;
    logic [CNT_W-1:0] fcnt;
    logic             side_pend;
    logic             ped_pend;
    logic             ped_serve;
    logic             blink;

    logic [2:0]       state_n;
    logic [CNT_W-1:0] tmr_n;
    logic [CNT_W-1:0] fcnt_n;
    logic             blink_n;
    logic             ped_serve_n;
    logic             enter_sg;
    logic             any_req;
    logic [5:0]       lamps_n;

    // Lamp decode {main RYG, side RYG}.  Unused codes show all red.
    function automatic logic [5:0] lamp_decode(input logic [2:0] s, input logic b);
        logic [5:0] l;
        case (s)
            S_MG:    l = {3'b001, 3'b100};
            S_MY:    l = {3'b010, 3'b100};
            S_AR1:   l = {3'b100, 3'b100};
            S_SG:    l = {3'b100, 3'b001};
            S_SY:    l = {3'b100, 3'b010};
            S_AR2:   l = {3'b100, 3'b100};
            S_FLASH: l = {1'b0, b, 1'b0, b, 2'b00};
            default: l = {3'b100, 3'b100};
        endcase
        return l;
    endfunction

    always_comb begin
        any_req = side_pend | side_req | ped_pend | ped_req | flash_en;
        state_n = state;
        case (state)
            S_MG:    if (tmr == MG_LAST && any_req) state_n = S_MY;
            S_MY:    if (tmr == YEL_LAST)           state_n = S_AR1;
            S_AR1:   if (tmr == CLR_LAST)           state_n = flash_en ? S_FLASH : S_SG;
            S_SG:    if (tmr == SG_LAST)            state_n = S_SY;
            S_SY:    if (tmr == YEL_LAST)           state_n = S_AR2;
            S_AR2:   if (tmr == CLR_LAST)           state_n = flash_en ? S_FLASH : S_MG;
            S_FLASH: if (!flash_en)                 state_n = S_AR2;
            default:                                state_n = S_MG;
        endcase

        enter_sg = (state_n == S_SG) && (state != S_SG);

        // Timer restarts on every state change; in MG it parks at the
        // minimum so a late request is served on the very next edge.
        if (state_n != state)
            tmr_n = '0;
        else if (state == S_MG && tmr == MG_LAST)
            tmr_n = tmr;
        else
            tmr_n = tmr + 1'b1;

        // Walk permission is decided once, at side-green entry.
        if (enter_sg)
            ped_serve_n = ped_pend | ped_req;
        else if (state_n != S_SG)
            ped_serve_n = 1'b0;
        else
            ped_serve_n = ped_serve;

        // Blink starts lit on flash entry and toggles every FLASH_HALF cycles.
        if (state_n == S_FLASH && state != S_FLASH) begin
            blink_n = 1'b1;
            fcnt_n  = '0;
        end else if (state_n == S_FLASH) begin
            if (fcnt == FH_LAST) begin
                blink_n = ~blink;
                fcnt_n  = '0;
            end else begin
                blink_n = blink;
                fcnt_n  = fcnt + 1'b1;
            end
        end else begin
            blink_n = 1'b0;
            fcnt_n  = '0;
        end

        lamps_n = lamp_decode(state_n, blink_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_MG;
            tmr       <= '0;
            fcnt      <= '0;
            side_pend <= 1'b0;
            ped_pend  <= 1'b0;
            ped_serve <= 1'b0;
            blink     <= 1'b0;
            main_lt   <= 3'b001;
            side_lt   <= 3'b100;
            ped_walk  <= 1'b0;
        end else begin
            state     <= state_n;
            tmr       <= tmr_n;
            fcnt      <= fcnt_n;
            // A request arriving in the side-green entry cycle counts as served.
            side_pend <= (side_pend | side_req) & ~enter_sg;
            ped_pend  <= (ped_pend | ped_req) & ~enter_sg;
            ped_serve <= ped_serve_n;
            blink     <= blink_n;
            main_lt   <= lamps_n[5:3];
            side_lt   <= lamps_n[2:0];
            ped_walk  <= (state_n == S_SG) & ped_serve_n;
        end
    end

endmodule
